uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive framer for the serial input path.
- Consumes the already-debounced, clk-synchronous rx line from the input glitch filter.
- Recovers 8N1 frames (8 data bits, no parity, 1 stop bit), LSB first, using a mid-bit sampling counter.
- Presents each received byte with a one-cycle valid pulse to the command/FIFO logic downstream.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600); minimum legal value 4.
- HALF, BAUD_DIV/2, cycles from start-edge detection to the start-bit sample (localparam, not overridable).
- CNT_W, $clog2(BAUD_DIV), bit-counter width (localparam).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- rx_in  input  1  filtered serial line; idle high; already synchronous to clk.
- rx_data  output  8  last good received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated with a good frame.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rx_data=0, rx_valid=0, frame_err=0, busy=0, cnt=0, bit_idx=0, shift=0, rx_q=1.
- rx_q is rx_in registered once and is used only for edge detection.
- Start-edge detection: define E0 as the clk edge at which state=IDLE, rx_q=1, rx_in=0.
  - At E0: enter START, cnt cleared to 0.
- START: cnt increments each cycle. At edge E0+HALF (cnt==HALF-1), rx_in is sampled:
  - rx_in=0: go to DATA, cnt=0, bit_idx=0.
  - rx_in=1: false start; return to IDLE, no pulse.
- DATA: data bit k (k=0..7) is sampled at edge E0+HALF+(k+1)*BAUD_DIV (cnt==BAUD_DIV-1; cnt then wraps to 0).
  - shift <= {rx_in, shift[7:1]} (LSB first).
  - After bit 7, go to STOP.
- STOP: sampled at edge E0+HALF+9*BAUD_DIV.
  - rx_in=1: rx_data<=shift; rx_valid=1 for exactly the following cycle.
  - rx_in=0: frame_err=1 for the following cycle; rx_data unchanged.
  - Either way, return to IDLE at that same edge.
- Re-arm: because of the rx_q==1 requirement, a held-low line (break) never retriggers. The next start needs a high-to-low transition.
- Back-to-back frames: the next start edge may arrive any time after the stop sample; it must be accepted.
- rx_valid and frame_err are never high together. Both are 0 in every cycle not listed above.
- rx_data holds its value between frames.
- Reset mid-frame: frame abandoned, no pulse, all outputs to reset values.
- Counter wrap: cnt never exceeds BAUD_DIV-1. bit_idx is 3 bits.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even).
  - Adds output parity_err (1 bit).
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled one BAUD_DIV after bit 7, and the stop sample moves out by one BAUD_DIV.
  - On parity mismatch with a good stop bit: parity_err pulses for one cycle, rx_valid is suppressed, rx_data is unchanged.
  - Framing error takes priority: frame_err only.
- Undefined: no PARITY state, no parity_err port, 8N1 timing exactly as above.

Decomposition:
- Package uart_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - UART_DATA_BITS=8;
  - UART_DEFAULT_BAUD_DIV=5208.
- One natural sub-module, uart_baud_timer:
  - inputs: clk, rst, clear;
  - outputs: half_tick (cnt==HALF-1) and bit_tick (cnt==BAUD_DIV-1);
  - parameterized by BAUD_DIV.
- The FSM and shift register stay in uart_rx.

Test Plan (all with BAUD_DIV=16, HALF=8):
- Send 0xA5, 8N1, falling edge at E0 -> rx_valid high only in the cycle after edge E0+152; rx_data=0xA5; frame_err stays 0; busy falls at E0+152.
- Drive rx_in low for 4 cycles, then high -> START sample at E0+8 reads 1; return to IDLE; no rx_valid/frame_err; busy high for cycles E0..E0+8 only.
- Send 0x3C with stop bit forced 0, then hold the line low for 40 cycles -> frame_err one-cycle pulse; rx_data keeps 0xA5; no second frame starts. Release high, then send 0x0F -> rx_valid, rx_data=0x0F.
- Send 0x00 then 0xFF with the second start edge 8 cycles after the first stop sample -> two rx_valid pulses, values 0x00 then 0xFF.
- Assert rst during data bit 4 of 0x77 -> all outputs 0 immediately, no pulse. After release, send 0x55 -> rx_valid, rx_data=0x55.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x01 with parity bit 0 -> parity_err pulse, no rx_valid. Send 0x01 with parity bit 1 -> rx_valid, rx_data=0x01.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_DEFAULT_BAUD_DIV = 5208;

endpackage
`default_nettype wire

// File: rtl/uart_baud_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_timer
// Brief    : Bit-period counter producing mid-start and full-bit sample ticks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic bit_tick
);

  localparam int HALF  = BAUD_DIV / 2;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wrapping at the bit tick keeps cnt within 0..BAUD_DIV-1 at all times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign half_tick = (r_cnt == C_HALF_LAST);
  assign bit_tick  = (r_cnt == C_BIT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receive framer with mid-bit sampling and pulse outputs.
//            Optional parity checking is enabled with UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_DEFAULT_BAUD_DIV
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  , output logic                    parity_err
`endif
);

  rx_state_t                 r_state;
  logic                      r_rx_q;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rx_data;
  logic                      r_rx_valid;
  logic                      r_frame_err;
  logic                      r_busy;
  logic                      w_clear;
  logic                      w_half_tick;
  logic                      w_bit_tick;
`ifdef UART_RX_PARITY_EN
  logic                      r_par_bad;
  logic                      r_parity_err;
  logic                      w_par_exp;

  assign w_par_exp  = (^r_shift) ^ PARITY_ODD;
  assign parity_err = r_parity_err;
`endif

  // Timer is held at zero while idle and restarts on a confirmed start bit.
  assign w_clear = (r_state == IDLE) || ((r_state == START) && w_half_tick);

  uart_baud_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_clear),
    .half_tick (w_half_tick),
    .bit_tick  (w_bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rx_q      <= 1'b1;
      r_bit_idx   <= 3'd0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_q      <= rx_in;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Requires a high-to-low transition, so a held break never re-arms.
          if (r_rx_q && !rx_in) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_half_tick) begin
            if (!rx_in) begin
              r_state   <= DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            r_shift <= {rx_in, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_tick) begin
            r_par_bad <= (rx_in != w_par_exp);
            r_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_bit_tick) begin
            if (rx_in) begin
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end
`else
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx at BAUD_DIV=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BAUD_DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN    = 1'b1;
  localparam int STOP_J    = 168;
  localparam int FRAME_LEN = 176;
`else
  localparam bit PAR_EN    = 1'b0;
  localparam int STOP_J    = 152;
  localparam int FRAME_LEN = 160;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Line waveform, one entry per clk edge starting at E0, plus observations.
  logic       wave[$];
  int         v_j[$];
  logic [7:0] v_d[$];
  int         fe_j[$];
  int         pe_j[$];
  int         busy_first, busy_last, n_busy;
  int         n_overlap = 0;

  task automatic add_bits(input logic v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic add_raw(input logic [7:0] d, input logic par_en, input logic par, input logic stop_bit);
    add_bits(1'b0, BAUD_DIV);
    for (int k = 0; k < 8; k++) add_bits(d[k], BAUD_DIV);
    if (par_en) add_bits(par, BAUD_DIV);
    add_bits(stop_bit, BAUD_DIV);
  endtask

  task automatic add_frame(input logic [7:0] d, input logic stop_bit);
    add_raw(d, PAR_EN, ^d, stop_bit);
  endtask

  // Drives wave[j] before edge j and records outputs after it.
  task automatic play(input int n);
    v_j.delete(); v_d.delete(); fe_j.delete(); pe_j.delete();
    busy_first = -1; busy_last = -1; n_busy = 0;
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      rx_in = (j < wave.size()) ? wave[j] : 1'b1;
      @(negedge clk);
      if (rx_valid) begin v_j.push_back(j); v_d.push_back(rx_data); end
      if (frame_err) fe_j.push_back(j);
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_j.push_back(j);
      if (parity_err && (rx_valid || frame_err)) n_overlap++;
`endif
      if (rx_valid && frame_err) n_overlap++;
      if (busy) begin
        if (busy_first < 0) busy_first = j;
        busy_last = j;
        n_busy++;
      end
    end
    wave.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
    n_chk++; if ({rx_valid, frame_err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {rx_valid, frame_err, busy}); end
    @(negedge clk); rst = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    add_frame(8'hA5, 1'b1); add_bits(1'b1, 20);
    play(FRAME_LEN + 20);
    n_chk++; if (v_j.size() !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", v_j.size()); end
    n_chk++; if ((v_j.size() > 0 ? v_j[0] : -1) !== STOP_J) begin n_fail++; $display("FAIL basic_valid_time: got %0d expected %0d", (v_j.size() > 0 ? v_j[0] : -1), STOP_J); end
    n_chk++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %0h expected a5", rx_data); end
    n_chk++; if (fe_j.size() !== 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses expected 0", fe_j.size()); end
    n_chk++; if (busy_first !== 0 || busy_last !== STOP_J - 1 || n_busy !== STOP_J) begin n_fail++; $display("FAIL basic_busy: got first %0d last %0d n %0d expected 0 %0d %0d", busy_first, busy_last, n_busy, STOP_J - 1, STOP_J); end
  endtask

  task automatic test_false_start();
    add_bits(1'b0, 4); add_bits(1'b1, 30);
    play(34);
    n_chk++; if (v_j.size() + fe_j.size() !== 0) begin n_fail++; $display("FAIL false_start_pulses: got %0d expected 0", v_j.size() + fe_j.size()); end
    n_chk++; if (busy_first !== 0 || busy_last !== 7 || n_busy !== 8) begin n_fail++; $display("FAIL false_start_busy: got first %0d last %0d n %0d expected 0 7 8", busy_first, busy_last, n_busy); end
    n_chk++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL false_start_data: got %0h expected a5", rx_data); end
  endtask

  task automatic test_frame_error();
    add_frame(8'h3C, 1'b0); add_bits(1'b0, 40);
    play(FRAME_LEN + 40);
    n_chk++; if (fe_j.size() !== 1 || (fe_j.size() > 0 ? fe_j[0] : -1) !== STOP_J) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses first %0d expected 1 at %0d", fe_j.size(), (fe_j.size() > 0 ? fe_j[0] : -1), STOP_J); end
    n_chk++; if (v_j.size() !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d pulses expected 0", v_j.size()); end
    n_chk++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_hold: got %0h expected a5", rx_data); end
    n_chk++; if (busy_last !== STOP_J - 1) begin n_fail++; $display("FAIL ferr_break_rearm: got busy_last %0d expected %0d", busy_last, STOP_J - 1); end
    add_bits(1'b1, 4); add_frame(8'h0F, 1'b1); add_bits(1'b1, 8);
    play(FRAME_LEN + 12);
    n_chk++; if (v_j.size() !== 1 || (v_j.size() > 0 ? v_j[0] : -1) !== 4 + STOP_J) begin n_fail++; $display("FAIL ferr_recover_valid: got %0d pulses first %0d expected 1 at %0d", v_j.size(), (v_j.size() > 0 ? v_j[0] : -1), 4 + STOP_J); end
    n_chk++; if (rx_data !== 8'h0F) begin n_fail++; $display("FAIL ferr_recover_data: got %0h expected 0f", rx_data); end
  endtask

  task automatic test_back_to_back();
    add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_bits(1'b1, 10);
    play(2 * FRAME_LEN + 10);
    n_chk++; if (v_j.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", v_j.size()); end
    n_chk++; if (v_j.size() > 1 && (v_d[0] !== 8'h00 || v_d[1] !== 8'hFF)) begin n_fail++; $display("FAIL b2b_data: got %0h %0h expected 00 ff", v_d[0], v_d[1]); end
    n_chk++; if (v_j.size() > 1 && (v_j[0] !== STOP_J || v_j[1] !== FRAME_LEN + STOP_J)) begin n_fail++; $display("FAIL b2b_time: got %0d %0d expected %0d %0d", v_j[0], v_j[1], STOP_J, FRAME_LEN + STOP_J); end
  endtask

  task automatic test_mid_reset();
    add_frame(8'h77, 1'b1);
    play(86);
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({rx_data, rx_valid, frame_err, busy} !== 11'd0) begin n_fail++; $display("FAIL midreset_outputs: got %0h expected 0", {rx_data, rx_valid, frame_err, busy}); end
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    add_bits(1'b1, 40);
    play(40);
    n_chk++; if (v_j.size() + fe_j.size() !== 0 || n_busy !== 0) begin n_fail++; $display("FAIL midreset_quiet: got pulses %0d busy %0d expected 0 0", v_j.size() + fe_j.size(), n_busy); end
    add_frame(8'h55, 1'b1); add_bits(1'b1, 8);
    play(FRAME_LEN + 8);
    n_chk++; if (v_j.size() !== 1 || rx_data !== 8'h55) begin n_fail++; $display("FAIL midreset_recover: got %0d pulses data %0h expected 1 55", v_j.size(), rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    add_raw(8'h01, 1'b1, 1'b0, 1'b1); add_bits(1'b1, 8);
    play(FRAME_LEN + 8);
    n_chk++; if (pe_j.size() !== 1 || (pe_j.size() > 0 ? pe_j[0] : -1) !== STOP_J) begin n_fail++; $display("FAIL parity_err_pulse: got %0d pulses expected 1 at %0d", pe_j.size(), STOP_J); end
    n_chk++; if (v_j.size() !== 0 || rx_data !== 8'h55) begin n_fail++; $display("FAIL parity_suppress: got %0d pulses data %0h expected 0 55", v_j.size(), rx_data); end
    add_raw(8'h01, 1'b1, 1'b1, 1'b1); add_bits(1'b1, 8);
    play(FRAME_LEN + 8);
    n_chk++; if (v_j.size() !== 1 || pe_j.size() !== 0 || rx_data !== 8'h01) begin n_fail++; $display("FAIL parity_good: got %0d valid %0d perr data %0h expected 1 0 01", v_j.size(), pe_j.size(), rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_chk++; if (n_overlap !== 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d expected 0", n_overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
